pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipe_pkg.sv | 12 +
 rtl/sat_counter.sv | 35 +++
 rtl/pipeline_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding and
// the default mul/div EX-stage occupancy.
package pipe_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        MULDIV = 1'b1
    } state_e;

    localparam int MULDIV_LAT_DEF = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible the cycle after inc; clr wins over inc; holds at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: branch flush, load-use stall, multi-cycle mul/div hold.
// Control outputs are combinational; a single mul/div stalls the front end MULDIV_LAT-1 cycles.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int MULDIV_LAT = MULDIV_LAT_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             branch_taken,
    input  logic             muldiv_start,
    input  logic             cnt_clr,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IDEX_Write,
    output logic             Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int            CW       = $clog2(MULDIV_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MULDIV_LAT - 2);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            load_use;

    assign load_use = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                      ((IDEX_rd == IFID_rs1) || (IDEX_rd == IFID_rs2));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        PC_Write     = 1'b1;
        IFID_Write   = 1'b1;
        IDEX_Write   = 1'b1;
        Flush        = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        busy         = 1'b0;
        // Gate on reset so inputs cannot leak through while the block is held.
        if (reset_n) begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        Flush = 1'b1;
                    end else if (muldiv_start) begin
                        PC_Write     = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_d        = CNT_LOAD;
                        state_d      = MULDIV;
                    end else if (load_use) begin
                        PC_Write    = 1'b0;
                        IFID_Write  = 1'b0;
                        IDEX_Bubble = 1'b1;
                    end
                end
                MULDIV: begin
                    busy = 1'b1;
                    if (branch_taken) begin
                        Flush   = 1'b1;
                        state_d = RUN;
                    end else if (cnt_q != '0) begin
                        PC_Write     = 1'b0;
                        IFID_Write   = 1'b0;
                        IDEX_Write   = 1'b0;
                        EXMEM_Bubble = 1'b1;
                        cnt_d        = cnt_q - 1'b1;
                    end else begin
                        // Release cycle: the result leaves EX, front end resumes.
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (!PC_Write),
        .count   (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (Flush),
        .count   (flush_events)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed hazard scenarios then random traffic, checked
// against a cycle model; a second instance with 4-bit counters covers saturation.
module tb_pipeline_ctrl;

    localparam int LAT = 4;
    localparam int W   = 32;
    localparam int WS  = 4;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         br, md, mr, clr;
    logic [4:0]   rd, rs1, rs2;

    logic         pc_w, ifid_w, idex_w, flush, idb, exb, busy;
    logic [W-1:0] stall_c, flush_c;
    logic         s_pc_w, s_ifid_w, s_idex_w, s_flush, s_idb, s_exb, s_busy;
    logic [WS-1:0] s_stall_c, s_flush_c;

    int     total = 0;
    int     bad   = 0;
    int     mul_left = 0;
    longint m_stall = 0;
    longint m_flush = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.MULDIV_LAT(LAT), .CNT_W(W)) dut (
        .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mr), .IDEX_rd(rd),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .branch_taken(br), .muldiv_start(md),
        .cnt_clr(clr), .PC_Write(pc_w), .IFID_Write(ifid_w), .IDEX_Write(idex_w),
        .Flush(flush), .IDEX_Bubble(idb), .EXMEM_Bubble(exb), .busy(busy),
        .stall_cycles(stall_c), .flush_events(flush_c)
    );

    pipeline_ctrl #(.MULDIV_LAT(LAT), .CNT_W(WS)) dut_small (
        .clk(clk), .reset_n(reset_n), .IDEX_MemRead(mr), .IDEX_rd(rd),
        .IFID_rs1(rs1), .IFID_rs2(rs2), .branch_taken(br), .muldiv_start(md),
        .cnt_clr(clr), .PC_Write(s_pc_w), .IFID_Write(s_ifid_w), .IDEX_Write(s_idex_w),
        .Flush(s_flush), .IDEX_Bubble(s_idb), .EXMEM_Bubble(s_exb), .busy(s_busy),
        .stall_cycles(s_stall_c), .flush_events(s_flush_c)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat(input longint v, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        return (64'(v) > mx) ? mx : 64'(v);
    endfunction

    // Expected controls, bit order {PC_Write, IFID_Write, IDEX_Write, Flush, IDEX_Bubble, EXMEM_Bubble, busy}.
    // mul_left = MULDIV cycles still to run (last one is the release cycle); 0 means running normally.
    function automatic logic [6:0] model_ctl();
        logic       lu;
        logic [6:0] e;
        e = 7'b1110000;
        if (!reset_n) return e;
        lu = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        if (mul_left == 0) begin
            if (br)      e[3] = 1'b1;
            else if (md) begin e[6:4] = 3'b000; e[1] = 1'b1; end
            else if (lu) begin e[6:5] = 2'b00;  e[2] = 1'b1; end
        end else begin
            e[0] = 1'b1;
            if (br)                 e[3] = 1'b1;
            else if (mul_left > 1)  begin e[6:4] = 3'b000; e[1] = 1'b1; end
        end
        return e;
    endfunction

    task automatic drive(input logic b, input logic m, input logic r,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic c);
        br = b; md = m; mr = r; rd = d; rs1 = s1; rs2 = s2; clr = c;
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        mul_left = 0;
        m_stall  = 0;
        m_flush  = 0;
    endtask

    task automatic check_all(input string tag);
        logic [6:0] e;
        e = model_ctl();
        chk({tag, "_ctl"},    64'({pc_w, ifid_w, idex_w, flush, idb, exb, busy}), 64'(e));
        chk({tag, "_sctl"},   64'({s_pc_w, s_ifid_w, s_idex_w, s_flush, s_idb, s_exb, s_busy}), 64'(e));
        chk({tag, "_stall"},  64'(stall_c),   sat(m_stall, W));
        chk({tag, "_flush"},  64'(flush_c),   sat(m_flush, W));
        chk({tag, "_sstall"}, 64'(s_stall_c), sat(m_stall, WS));
        chk({tag, "_sflush"}, 64'(s_flush_c), sat(m_flush, WS));
    endtask

    // Called just after a falling edge with inputs driven; returns after the next falling edge.
    task automatic cycle(input string tag);
        logic [6:0] e;
        #1;
        check_all(tag);
        e = model_ctl();
        @(posedge clk);
        if (reset_n) begin
            if (clr) begin
                m_stall = 0;
                m_flush = 0;
            end else begin
                m_stall += longint'(!e[6]);
                m_flush += longint'(e[3]);
            end
            if (mul_left == 0) begin
                if (!br && md) mul_left = LAT - 1;
            end else begin
                mul_left = br ? 0 : mul_left - 1;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
            cycle("idle");
        end
    endtask

    initial begin
        // Reset with every input asserted: outputs must still be the defaults.
        drive(1, 1, 1, 5'd5, 5'd5, 5'd5, 0);
        do_reset();
        cycle("reset");
        cycle("reset_hold");
        reset_n = 1'b1;
        idle(1);

        drive(0, 0, 1, 5'd5, 5'd1, 5'd5, 0);
        cycle("loaduse");
        idle(1);
        chk("loaduse_count", 64'(stall_c), 64'd1);

        drive(0, 0, 1, 5'd0, 5'd0, 5'd3, 0);
        cycle("x0_load");
        chk("x0_no_stall", 64'(stall_c), 64'd1);

        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("muldiv_start");
        chk("muldiv_busy1", 64'(busy), 64'd1);
        idle(4);
        chk("muldiv_stalls", 64'(stall_c), 64'd4);
        chk("muldiv_done", 64'(busy), 64'd0);

        drive(1, 1, 1, 5'd7, 5'd7, 5'd7, 0);
        cycle("priority");
        idle(1);
        chk("priority_flushes", 64'(flush_c), 64'd1);
        chk("priority_stalls", 64'(stall_c), 64'd4);

        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("abort_start");
        idle(1);
        drive(1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("abort_br");
        idle(1);
        chk("abort_run", 64'(busy), 64'd0);

        for (int k = 0; k < 7; k++) begin
            drive(0, 1, 1, 5'd2, 5'd2, 5'd0, 0);
            cycle("b2b");
        end
        idle(3);

        drive(0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
        cycle("rstmid_start");
        idle(1);
        do_reset();
        #1;
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_stall", 64'(stall_c), 64'd0);
        chk("rstmid_flush", 64'(flush_c), 64'd0);
        cycle("rstmid_hold");
        reset_n = 1'b1;
        idle(1);

        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1, 5'd9, 5'd9, 5'd9, 0);
            cycle("saturate");
        end
        chk("sat_small", 64'(s_stall_c), 64'd15);
        chk("sat_wide", 64'(stall_c), 64'd20);
        drive(0, 0, 1, 5'd9, 5'd9, 5'd9, 1);
        cycle("clr_with_stall");
        chk("clr_small", 64'(s_stall_c), 64'd0);
        chk("clr_wide", 64'(stall_c), 64'd0);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(299) == 0) do_reset();
            else reset_n = 1'b1;
            drive(($urandom_range(7) == 0), ($urandom_range(5) == 0), ($urandom_range(1) == 0),
                  5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                  ($urandom_range(49) == 0));
            cycle("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
